reg_writeback: RTL
==================

# reg_writeback

Writeback queue sitting between the result producers (ALU, instruction decoder) and the 8×32 general-purpose register file's single write port. It accepts write requests from both producers over valid/ready handshakes, arbitrates round-robin, buffers them in an in-order queue and retires at most one per cycle. It drives the register file's write address, ALU/ID value pair, data-select and write-enable signals, and publishes a per-register pending mask for hazard stalls.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16
- DATA_W, 32: data width
- ADDR_W, 3: register address width (8 registers)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- alu_valid  in  1  ALU write request
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this edge when high with alu_valid
- id_valid  in  1  decoder write request (immediate/move)
- id_addr  in  ADDR_W  decoder destination register
- id_data  in  DATA_W  decoder value
- id_ready  out  1  decoder request accepted this edge when high with id_valid
- wb_addr  out  ADDR_W  to register file write_addr
- wb_value_alu  out  DATA_W  to register file write_value_alu
- wb_value_id  out  DATA_W  to register file write_value_id
- wb_data_sel  out  1  1 = ALU source, 0 = ID source
- wb_enable  out  1  to register file write_enable
- pend_mask  out  2^ADDR_W  bit r set while any write to register r is queued or in the output stage
- count  out  clog2(DEPTH)+1  queued entries (output stage excluded)

## Operation
- Queue: circular buffer, DEPTH entries of {addr, data, src}; rd/wr pointers wrap modulo DEPTH; strict FIFO order.
- Arbitration: at most one enqueue per cycle. Only one valid → that one granted. Both valid → round-robin by last_grant flag (reset value: ID, so ALU wins first tie); flag updates only on an actual accept.
- Ready: alu_ready/id_ready low when count == DEPTH; otherwise high only for the granted source (loser sees ready low). Ready never depends on same-cycle pop.
- Output stage: registers wb_*. Each edge: if queue non-empty, pop head into output stage, wb_enable=1; else wb_enable=0. Selected source's value on its wb_value_* bus, the other bus driven 0; wb_addr and wb_data_sel from entry.
- Simultaneous push and pop: both occur; count unchanged.
- Same register written twice: both retire in acceptance order; last write wins in register file.
- pend_mask: OR of one-hot(addr) over valid queue entries plus output stage when wb_enable=1; combinational from registered state.
- Reset (any time, including mid-burst): queue flushed, pointers 0, count 0, wb_enable 0, wb_addr 0, wb_value_alu/id 0, wb_data_sel 0, pend_mask 0, last_grant = ID. Requests in flight are discarded; producers must reissue.

## Timing
- Accept at edge N → popped to output stage at edge N+1 (if queue empty before N) → register file captures at edge N+2.
- Throughput: one retirement per cycle; sustained one request per cycle with no stall.
- Full queue: requests stall until a pop drops count below DEPTH; ready rises the cycle after the pop edge.
- wb_enable pulses exactly one cycle per retired entry; back-to-back entries give continuous high.

## Configuration
- WB_BYPASS_EN defined: when queue empty (count 0) and a request is accepted at edge N, it loads the output stage directly at edge N (skips queue); wb_enable high in cycle after N, capture at N+1. Ordering preserved since bypass only occurs with empty queue.
- Undefined: every request passes through the queue; latency as in Timing.

## Test plan
- Reset: drive reset low mid-cycle with 3 entries queued → all outputs 0, count 0, pend_mask 0 immediately; after release, alu_ready=1.
- Single ALU write r3=0xDEADBEEF → wb_enable one cycle, wb_addr=3, wb_data_sel=1, wb_value_alu=0xDEADBEEF, wb_value_id=0; pend_mask[3] set from accept until retire.
- Tie: both valid 4 cycles (ALU r1=1,2; ID r2=0xA,0xB) → accepts alternate ALU, ID, ALU, ID; retire order matches.
- Full: hold wb popping impossible by 5 back-to-back requests with DEPTH=2 stress → ready low when count==DEPTH, no loss, all 5 retire in order.
- WAW: ID r5=7 then ALU r5=9 → two retirements, final register file r5=9, pend_mask[5] clears after second.
- WB_BYPASS_EN: empty queue, ALU r0=0x55 accepted at edge N → wb_enable high after edge N, count stays 0.

Source files
------------

// File: rtl/reg_writeback.sv
// Writeback queue: round-robin arbitration of ALU/decoder register writes into an
// in-order circular buffer feeding the register file write port. Optional WB_BYPASS_EN.
module reg_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int NREG  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_addr,
  input  logic [DATA_W-1:0] id_data,
  output logic              id_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_value_alu,
  output logic [DATA_W-1:0] wb_value_id,
  output logic              wb_data_sel,
  output logic              wb_enable,
  output logic [NREG-1:0]   pend_mask,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic              q_src  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, ofs;
  logic [CNT_W-1:0]  count_q;
  logic              last_id;
  logic              not_full, id_gnt, alu_acc, id_acc, push, pop, bypass, enq;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_src;

  // Handshake: a request transfers on the rising edge where valid && ready are both
  // high. Ready depends only on registered occupancy and the grant, never on the pop.
  always_comb begin
    not_full  = (count_q != CNT_W'(DEPTH));
    id_gnt    = id_valid && (!alu_valid || !last_id);
    alu_ready = not_full && !id_gnt;
    id_ready  = not_full && id_gnt;
    alu_acc   = alu_valid && alu_ready;
    id_acc    = id_valid && id_ready;
    push      = alu_acc || id_acc;
    in_addr   = alu_acc ? alu_addr : id_addr;
    in_data   = alu_acc ? alu_data : id_data;
    in_src    = alu_acc;
    pop       = (count_q != '0);
`ifdef WB_BYPASS_EN
    bypass    = push && (count_q == '0);
`else
    bypass    = 1'b0;
`endif
    enq       = push && !bypass;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[wr_ptr] <= in_addr;
      q_data[wr_ptr] <= in_data;
      q_src[wr_ptr]  <= in_src;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      last_id      <= 1'b1;
      wb_addr      <= '0;
      wb_value_alu <= '0;
      wb_value_id  <= '0;
      wb_data_sel  <= 1'b0;
      wb_enable    <= 1'b0;
    end else begin
      if (push) last_id <= id_acc;
      if (enq)  wr_ptr  <= wr_ptr + 1'b1;
      if (pop)  rd_ptr  <= rd_ptr + 1'b1;
      if (enq && !pop)      count_q <= count_q + 1'b1;
      else if (!enq && pop) count_q <= count_q - 1'b1;
      if (pop) begin
        wb_enable    <= 1'b1;
        wb_addr      <= q_addr[rd_ptr];
        wb_data_sel  <= q_src[rd_ptr];
        wb_value_alu <= q_src[rd_ptr] ? q_data[rd_ptr] : '0;
        wb_value_id  <= q_src[rd_ptr] ? '0 : q_data[rd_ptr];
      end else if (bypass) begin
        wb_enable    <= 1'b1;
        wb_addr      <= in_addr;
        wb_data_sel  <= in_src;
        wb_value_alu <= in_src ? in_data : '0;
        wb_value_id  <= in_src ? '0 : in_data;
      end else begin
        wb_enable    <= 1'b0;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    pend_mask = '0;
    ofs       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ofs = PTR_W'(i) - rd_ptr;
      if (CNT_W'(ofs) < count_q) pend_mask[q_addr[i]] = 1'b1;
    end
    if (wb_enable) pend_mask[wb_addr] = 1'b1;
  end

  assign count = count_q;

endmodule
